wr_pkt_admit: RTL

- Write-domain front end that sits directly upstream of the write-pointer/full block of the async FIFO.
- Accepts a valid/ready packet stream and drives wr_inc/wr_data into the FIFO write port.
- Packets are admitted atomically: a packet starts only when the FIFO has free space for all of its words.
- Also publishes a write-side fill level, an almost-full flag and drop/error statistics.

---
 rtl/fifo_pkg.sv | 37 +++
 rtl/fifo_level_calc.sv | 57 +++++
 rtl/wr_pkt_admit.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module  : fifo_pkg
// Purpose : Shared types and helpers for the async FIFO write/read front ends.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_pkg;

    // Widest pointer the helpers handle; callers cast down to their width.
    localparam int PTR_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        STREAM = 2'd2,
        DROP   = 2'd3
    } adm_state_e;

    function automatic int unsigned depth_of(input int unsigned addr_size);
        return 32'd1 << addr_size;
    endfunction

    // Zero-extended Gray codes convert correctly: the leading zeros add nothing
    // to the prefix XOR.
    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage : fifo_pkg

`default_nettype wire

// File: rtl/fifo_level_calc.sv
// ============================================================================
// Module  : fifo_level_calc
// Purpose : Gray-pointer occupancy, free space, registered level/almost-full.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_level_calc
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = 4,
    parameter int AF_MARGIN = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [ADDR_SIZE:0] lead_gray_i,
    input  logic [ADDR_SIZE:0] lag_gray_i,
    output logic [ADDR_SIZE:0] free_o,
    output logic [ADDR_SIZE:0] level_o,
    output logic               almost_full_o
);

    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = depth_of(ADDR_SIZE);

    localparam logic [PW-1:0] DEPTH_P   = PW'(DEPTH);
    localparam logic [PW-1:0] AF_THRESH = PW'(DEPTH - AF_MARGIN);

    logic [PW-1:0] w_lead_bin;
    logic [PW-1:0] w_lag_bin;
    logic [PW-1:0] w_lvl;
    logic [PW-1:0] level_q;
    logic          almost_full_q;

    assign w_lead_bin = PW'(gray2bin(PTR_MAX_W'(lead_gray_i)));
    assign w_lag_bin  = PW'(gray2bin(PTR_MAX_W'(lag_gray_i)));

    // The extra wrap bit makes the modulo subtraction distinguish full from empty.
    assign w_lvl  = w_lead_bin - w_lag_bin;
    assign free_o = DEPTH_P - w_lvl;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            level_q       <= w_lvl;
            almost_full_q <= (w_lvl >= AF_THRESH);
        end
    end

    assign level_o       = level_q;
    assign almost_full_o = almost_full_q;

endmodule : fifo_level_calc

`default_nettype wire

// File: rtl/wr_pkt_admit.sv
// ============================================================================
// Module  : wr_pkt_admit
// Purpose : Atomic packet admission into the async FIFO write port.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module wr_pkt_admit
    import fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_SIZE = 4,
    parameter int LEN_W     = 5,
    parameter int AF_MARGIN = 2
) (
    input  logic               wr_clk,
    input  logic               wr_rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [DATA_W-1:0]  s_data,
    input  logic [LEN_W-1:0]   s_len,
    input  logic               s_last,
    input  logic               wr_full,
    input  logic [ADDR_SIZE:0] wr_ptr,
    input  logic [ADDR_SIZE:0] wr_q2_rptr,
    output logic               wr_inc,
    output logic [DATA_W-1:0]  wr_data,
    output logic [ADDR_SIZE:0] wr_level,
    output logic               wr_almost_full,
    output logic               len_err,
    output logic [15:0]        drop_cnt
);

    localparam int PW    = ADDR_SIZE + 1;
    localparam int DEPTH = depth_of(ADDR_SIZE);
    localparam int CMP_W = (LEN_W > PW) ? LEN_W : PW;

    localparam logic [CMP_W-1:0] DEPTH_C = CMP_W'(DEPTH);
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    adm_state_e       state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_seen_q, err_seen_d;
    logic             len_err_q, len_err_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;

    logic [PW-1:0]    w_free;
    logic [CMP_W-1:0] w_free_c;
    logic [CMP_W-1:0] w_len_c;
    logic             w_accept;
    logic             w_final;

    fifo_level_calc #(
        .ADDR_SIZE (ADDR_SIZE),
        .AF_MARGIN (AF_MARGIN)
    ) u_level (
        .clk_i         (wr_clk),
        .rst_ni        (wr_rst),
        .lead_gray_i   (wr_ptr),
        .lag_gray_i    (wr_q2_rptr),
        .free_o        (w_free),
        .level_o       (wr_level),
        .almost_full_o (wr_almost_full)
    );

    assign w_free_c = CMP_W'(w_free);
    assign w_len_c  = CMP_W'(len_q);
    assign w_final  = (cnt_q == (len_q - LEN_ONE));
    assign w_accept = (state_q == STREAM) && s_valid && !wr_full;

    always_ff @(posedge wr_clk or negedge wr_rst) begin
        if (!wr_rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            err_seen_q <= 1'b0;
            len_err_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            err_seen_q <= err_seen_d;
            len_err_q  <= len_err_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_seen_d = err_seen_q;
        len_err_d  = 1'b0;
        drop_cnt_d = drop_cnt_q;
        s_ready    = 1'b0;
        wr_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                err_seen_d = 1'b0;
                cnt_d      = '0;
                if (s_valid) begin
                    len_d   = s_len;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if ((len_q == '0) || (w_len_c > DEPTH_C)) begin
                    state_d = DROP;
                    if (drop_cnt_q != 16'hFFFF) begin
                        drop_cnt_d = drop_cnt_q + 16'd1;
                    end
                end else if (w_free_c >= w_len_c) begin
                    state_d = STREAM;
                    cnt_d   = '0;
                end
            end

            STREAM: begin
                // A full flag here means the pointer block disagrees with our
                // admission; stalling is the only lossless response.
                s_ready = !wr_full;
                wr_inc  = w_accept;
                if (w_accept) begin
                    if (w_final) begin
                        state_d   = IDLE;
                        len_err_d = err_seen_q | !s_last;
                    end else begin
                        cnt_d = cnt_q + LEN_ONE;
                        if (s_last) begin
                            err_seen_d = 1'b1;
                        end
                    end
                end
            end

            DROP: begin
                s_ready = 1'b1;
                if (s_valid && s_last) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign wr_data  = s_data;
    assign len_err  = len_err_q;
    assign drop_cnt = drop_cnt_q;

endmodule : wr_pkt_admit

`default_nettype wire
